// File: rtl/base_arate.sv
// ---------------------------------------------------------------------------
// Module   : base_arate
// Purpose  : Token-bucket rate limiter for a valid/ready stream. Transfers
//            pass only while tokens are available. One token is added every
//            cfg_period+1 cycles, and the bucket is capped at cfg_max.
//            Gating is purely combinational (zero latency). A saturating
//            counter records the cycles in which the limiter held back a
//            valid transfer.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            cfg_en                - 1 = limiting active, 0 = bypass
//            cfg_period            - refill interval minus one
//            cfg_max               - bucket capacity
//            i_v / i_r / i_d       - upstream valid / ready / data
//            o_v / o_r / o_d       - downstream valid / ready / data
//            tokens                - current token count (registered)
//            stall_cnt / stall_clr - saturating stall counter and its clear
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module base_arate #(
  parameter int DWIDTH = 8,
  parameter int TOKW   = 4,
  parameter int PERW   = 8,
  parameter int STW    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic [PERW-1:0]   cfg_period,
  input  logic [TOKW-1:0]   cfg_max,
  input  logic              i_v,
  output logic              i_r,
  input  logic [DWIDTH-1:0] i_d,
  output logic              o_v,
  input  logic              o_r,
  output logic [DWIDTH-1:0] o_d,
  output logic [TOKW-1:0]   tokens,
  output logic [STW-1:0]    stall_cnt,
  input  logic              stall_clr
);

  logic [PERW-1:0] timer_q, timer_d;
  logic [TOKW-1:0] tokens_q, tokens_d;
  logic [STW-1:0]  stall_q, stall_d;

  logic            has_tok;
  logic            en;
  logic            take;
  logic            tick;
  logic [TOKW:0]   tok_sum;

  assign has_tok = (tokens_q != '0);
  assign en      = ~cfg_en | has_tok;

  // Zero-latency gating; the data path is never inspected.
  assign o_v = i_v & en;
  assign i_r = o_r & en;
  assign o_d = i_d;

  assign take = cfg_en & i_v & o_r & has_tok;

  // Using >= rather than == means a period shrunk below the current timer
  // value produces a tick on the very next edge instead of wrapping the
  // timer through its whole range.
  assign tick = (timer_q >= cfg_period);

  always_comb begin
    timer_d = timer_q + PERW'(1);
    if (tick) begin
      timer_d = '0;
    end
  end

  // One extra bit so a tick at full scale cannot wrap before the cap is
  // applied; take only happens with tokens_q != 0, so no underflow.
  assign tok_sum = ({1'b0, tokens_q} + (TOKW+1)'(tick)) - (TOKW+1)'(take);

  always_comb begin
    tokens_d = tok_sum[TOKW-1:0];
    // The cap also applies without tick/take, so lowering cfg_max clamps
    // the bucket on the next edge.
    if (tok_sum > {1'b0, cfg_max}) begin
      tokens_d = cfg_max;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (stall_clr) begin
      stall_d = '0;
    end else if (cfg_en && i_v && !has_tok && !(&stall_q)) begin
      stall_d = stall_q + STW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q  <= '0;
      tokens_q <= '0;
      stall_q  <= '0;
    end else begin
      timer_q  <= timer_d;
      tokens_q <= tokens_d;
      stall_q  <= stall_d;
    end
  end

  assign tokens    = tokens_q;
  assign stall_cnt = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_base_arate.sv
// ---------------------------------------------------------------------------
// Module   : tb_base_arate
// Purpose  : Self-checking bench for base_arate (TOKW=4, PERW=8, STW=4).
//            A reference model tracks timer/tokens/stall; data of every
//            expected transfer is queued and compared at the output.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_base_arate;

  logic       clk;
  logic       rst_n;
  logic       cfg_en;
  logic [7:0] cfg_period;
  logic [3:0] cfg_max;
  logic       i_v;
  logic       i_r;
  logic [7:0] i_d;
  logic       o_v;
  logic       o_r;
  logic [7:0] o_d;
  logic [3:0] tokens;
  logic [3:0] stall_cnt;
  logic       stall_clr;

  int n_checks = 0;
  int n_errors = 0;

  int m_timer = 0;
  int m_tok   = 0;
  int m_stall = 0;

  logic [7:0] sb_q[$];

  base_arate #(
    .DWIDTH(8),
    .TOKW  (4),
    .PERW  (8),
    .STW   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_en    (cfg_en),
    .cfg_period(cfg_period),
    .cfg_max   (cfg_max),
    .i_v       (i_v),
    .i_r       (i_r),
    .i_d       (i_d),
    .o_v       (o_v),
    .o_r       (o_r),
    .o_d       (o_d),
    .tokens    (tokens),
    .stall_cnt (stall_cnt),
    .stall_clr (stall_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output side of the scoreboard: every handshake at the output must match
  // the oldest expected transfer; an expected transfer that does not occur
  // is reported as missing.
  always @(negedge clk) begin
    if (o_v && o_r) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: transfer o_d=%h seen, none expected", o_d);
      end else begin
        logic [7:0] exp_d;
        exp_d = sb_q.pop_front();
        if (o_d !== exp_d) begin
          n_errors++;
          $display("FAIL sb_data: o_d=%h expected %h", o_d, exp_d);
        end
      end
    end else if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_missing: no transfer, expected data %h", sb_q[0]);
      sb_q.delete();
    end
  end

  // One clock cycle: new random data, queue the expected transfer, advance
  // the reference model on the edge.
  task automatic step();
    int  nt;
    bit  tk;
    bit  tkn;
    i_d = 8'($urandom);
    #1;
    if (rst_n && i_v && o_r && (!cfg_en || m_tok != 0)) sb_q.push_back(i_d);
    @(posedge clk);
    tk  = (m_timer >= int'(cfg_period));
    tkn = cfg_en && i_v && o_r && (m_tok != 0);
    if (stall_clr) m_stall = 0;
    else if (cfg_en && i_v && m_tok == 0 && m_stall < 15) m_stall++;
    m_timer = tk ? 0 : m_timer + 1;
    nt = m_tok + (tk ? 1 : 0) - (tkn ? 1 : 0);
    if (nt > int'(cfg_max)) nt = int'(cfg_max);
    m_tok = nt;
    #1;
  endtask

  task automatic apply_reset();
    i_v       = 1'b0;
    o_r       = 1'b0;
    stall_clr = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_timer = 0;
    m_tok   = 0;
    m_stall = 0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_en = 1'b1; cfg_period = 8'd3; cfg_max = 4'd2;
    i_v = 1'b1; o_r = 1'b1; stall_clr = 1'b0; i_d = 8'h00;
    #1;
    n_checks++;
    if (tokens !== 4'd0 || stall_cnt !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_state: tokens=%0d stall=%0d expected 0/0", tokens, stall_cnt);
    end
    n_checks++;
    if (o_v !== 1'b0 || i_r !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_gate: o_v=%b i_r=%b expected 0/0", o_v, i_r);
    end
    cfg_en = 1'b0; i_v = 1'b1; o_r = 1'b0;
    #1;
    n_checks++;
    if (o_v !== 1'b1 || i_r !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_bypass_a: o_v=%b i_r=%b expected 1/0", o_v, i_r);
    end
    i_v = 1'b0; o_r = 1'b1;
    #1;
    n_checks++;
    if (o_v !== 1'b0 || i_r !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_bypass_b: o_v=%b i_r=%b expected 0/1", o_v, i_r);
    end
    cfg_en = 1'b1;
    apply_reset();
  endtask

  task automatic test_rate();
    apply_reset();
    cfg_en = 1'b1; cfg_period = 8'd3; cfg_max = 4'd2; i_v = 1'b1; o_r = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      bit exp_v;
      exp_v = (k >= 5) && ((k - 1) % 4 == 0);
      #1;
      n_checks++;
      if (o_v !== exp_v || i_r !== exp_v) begin
        n_errors++;
        $display("FAIL rate_gate c%0d: o_v=%b i_r=%b expected %b", k, o_v, i_r, exp_v);
      end
      step();
      n_checks++;
      if (tokens !== 4'(m_tok) || stall_cnt !== 4'(m_stall)) begin
        n_errors++;
        $display("FAIL rate_state c%0d: tokens=%0d stall=%0d expected %0d/%0d",
                 k, tokens, stall_cnt, m_tok, m_stall);
      end
    end
    n_checks++;
    if (tokens !== 4'd1 || stall_cnt !== 4'd13) begin
      n_errors++;
      $display("FAIL rate_end: tokens=%0d stall=%0d expected 1/13", tokens, stall_cnt);
    end
  endtask

  task automatic test_burst();
    apply_reset();
    cfg_en = 1'b1; cfg_period = 8'd3; cfg_max = 4'd2; o_r = 1'b1; i_v = 1'b0;
    for (int k = 0; k < 20; k++) step();
    n_checks++;
    if (tokens !== 4'd2) begin
      n_errors++;
      $display("FAIL burst_fill: tokens=%0d expected 2", tokens);
    end
    i_v = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      bit exp_v;
      exp_v = (j == 1) || (j == 2) || ((j >= 5) && ((j - 1) % 4 == 0));
      #1;
      n_checks++;
      if (o_v !== exp_v) begin
        n_errors++;
        $display("FAIL burst_gate c%0d: o_v=%b expected %b", j, o_v, exp_v);
      end
      step();
    end
  endtask

  task automatic test_clamp();
    apply_reset();
    cfg_en = 1'b1; cfg_period = 8'd3; cfg_max = 4'd2; o_r = 1'b1; i_v = 1'b0;
    for (int k = 0; k < 12; k++) step();
    n_checks++;
    if (tokens !== 4'd2) begin
      n_errors++;
      $display("FAIL clamp_fill: tokens=%0d expected 2", tokens);
    end
    cfg_max = 4'd1;
    step();
    n_checks++;
    if (tokens !== 4'd1) begin
      n_errors++;
      $display("FAIL clamp_lower: tokens=%0d expected 1", tokens);
    end
    i_v = 1'b1;
    #1;
    n_checks++;
    if (o_v !== 1'b1) begin
      n_errors++;
      $display("FAIL clamp_first: o_v=%b expected 1", o_v);
    end
    step();
    #1;
    n_checks++;
    if (o_v !== 1'b0 || tokens !== 4'd0) begin
      n_errors++;
      $display("FAIL clamp_second: o_v=%b tokens=%0d expected 0/0", o_v, tokens);
    end
    step();
    i_v = 1'b0;
  endtask

  task automatic test_tick_take();
    apply_reset();
    cfg_en = 1'b1; cfg_period = 8'd3; cfg_max = 4'd3; o_r = 1'b1; i_v = 1'b0;
    for (int k = 0; k < 15; k++) step();
    n_checks++;
    if (tokens !== 4'd3) begin
      n_errors++;
      $display("FAIL tt_fill: tokens=%0d expected 3", tokens);
    end
    i_v = 1'b1;
    step();
    n_checks++;
    if (tokens !== 4'd3) begin
      n_errors++;
      $display("FAIL tt_coincide: tokens=%0d expected 3", tokens);
    end
    i_v = 1'b0;
    step();
    n_checks++;
    if (tokens !== 4'd3) begin
      n_errors++;
      $display("FAIL tt_hold: tokens=%0d expected 3", tokens);
    end
    for (int k = 0; k < 3; k++) step();
    n_checks++;
    if (tokens !== 4'd3) begin
      n_errors++;
      $display("FAIL tt_cap: tokens=%0d expected 3", tokens);
    end
  endtask

  task automatic test_bypass();
    apply_reset();
    cfg_en = 1'b0; cfg_period = 8'd0; cfg_max = 4'd5;
    for (int k = 0; k < 12; k++) begin
      logic [3:0] prev;
      i_v = 1'($urandom);
      o_r = k[0];
      #1;
      n_checks++;
      if (o_v !== i_v || i_r !== o_r) begin
        n_errors++;
        $display("FAIL bypass_gate c%0d: o_v=%b i_r=%b expected %b/%b", k, o_v, i_r, i_v, o_r);
      end
      prev = tokens;
      step();
      n_checks++;
      if (tokens < prev || stall_cnt !== 4'd0) begin
        n_errors++;
        $display("FAIL bypass_state c%0d: tokens=%0d (was %0d) stall=%0d expected stall 0",
                 k, tokens, prev, stall_cnt);
      end
    end
    n_checks++;
    if (tokens !== 4'd5) begin
      n_errors++;
      $display("FAIL bypass_fill: tokens=%0d expected 5", tokens);
    end
    cfg_period = 8'd255; cfg_en = 1'b1; i_v = 1'b1; o_r = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      bit exp_v;
      exp_v = (j <= 5);
      #1;
      n_checks++;
      if (o_v !== exp_v) begin
        n_errors++;
        $display("FAIL bypass_burst c%0d: o_v=%b expected %b", j, o_v, exp_v);
      end
      step();
    end
    i_v = 1'b0;
  endtask

  task automatic test_stall();
    apply_reset();
    cfg_en = 1'b1; cfg_period = 8'd255; cfg_max = 4'd2; i_v = 1'b1; o_r = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      n_checks++;
      if (stall_cnt !== 4'((k < 15) ? k : 15)) begin
        n_errors++;
        $display("FAIL stall_sat c%0d: stall=%0d expected %0d", k, stall_cnt, (k < 15) ? k : 15);
      end
    end
    stall_clr = 1'b1;
    step();
    n_checks++;
    if (stall_cnt !== 4'd0) begin
      n_errors++;
      $display("FAIL stall_clr: stall=%0d expected 0", stall_cnt);
    end
    stall_clr = 1'b0;
    step();
    n_checks++;
    if (stall_cnt !== 4'd1) begin
      n_errors++;
      $display("FAIL stall_resume: stall=%0d expected 1", stall_cnt);
    end
    i_v = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cfg_en = 1'b1; cfg_period = 8'd0; cfg_max = 4'd3; o_r = 1'b1; i_v = 1'b0;
    for (int k = 0; k < 4; k++) step();
    n_checks++;
    if (tokens !== 4'd3) begin
      n_errors++;
      $display("FAIL rmid_fill: tokens=%0d expected 3", tokens);
    end
    i_v = 1'b1;
    step();
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tokens !== 4'd0 || o_v !== 1'b0 || i_r !== 1'b0) begin
      n_errors++;
      $display("FAIL rmid_async: tokens=%0d o_v=%b i_r=%b expected 0/0/0", tokens, o_v, i_r);
    end
    m_timer = 0; m_tok = 0; m_stall = 0;
    @(posedge clk);
    #1;
    i_v   = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rate();
    test_burst();
    test_clamp();
    test_tick_take();
    test_bypass();
    test_stall();
    test_reset_mid();
    @(posedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover: %0d expected transfers never seen", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
